core_decode_stage: RTL and testbench

// Registered, parametrised RV32I decode stage between fetch and execute. Decodes every

---
 rtl/core_decode_pkg.sv | 62 ++++++
 rtl/core_decode_comb.sv | 139 +++++++++++++
 rtl/core_decode_stage.sv | 109 ++++++++++
 tb/tb_core_decode_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_decode_pkg.sv
// Shared RV32I decode constants: opcodes, funct3/funct7 values, ALU op encodings and
// memory access size codes used by the decode stage and its combinational decoder.
package core_decode_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [2:0] FUNCT3_ADD  = 3'd0;
  localparam logic [2:0] FUNCT3_SLL  = 3'd1;
  localparam logic [2:0] FUNCT3_SLT  = 3'd2;
  localparam logic [2:0] FUNCT3_SLTU = 3'd3;
  localparam logic [2:0] FUNCT3_XOR  = 3'd4;
  localparam logic [2:0] FUNCT3_SR   = 3'd5;
  localparam logic [2:0] FUNCT3_OR   = 3'd6;
  localparam logic [2:0] FUNCT3_AND  = 3'd7;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Base (funct7 == 0) ALU operation for the OP / OP-IMM funct3 field.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      FUNCT3_ADD:  op = ALU_ADD;
      FUNCT3_SLL:  op = ALU_SLL;
      FUNCT3_SLT:  op = ALU_SLT;
      FUNCT3_SLTU: op = ALU_SLTU;
      FUNCT3_XOR:  op = ALU_XOR;
      FUNCT3_SR:   op = ALU_SRL;
      FUNCT3_OR:   op = ALU_OR;
      default:     op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/core_decode_comb.sv
// Pure combinational RV32I decoder: one instruction word plus its PC in, one execute
// control bundle out. Illegal encodings collapse to an all-disabled bundle with illegal set.
module core_decode_comb
  import core_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic [31:0]           instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic [REG_AW-1:0]     rs1_o,
  output logic [REG_AW-1:0]     rs2_o,
  output logic [REG_AW-1:0]     rd_o,
  output logic                  sel_a_o,
  output logic                  sel_b_o,
  output logic [XLEN-1:0]       imm_a_o,
  output logic [XLEN-1:0]       imm_b_o,
  output logic                  reg_we_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [1:0]            mem_size_o,
  output logic                  mem_uns_o,
  output logic                  branch_o,
  output logic [2:0]            cond_o,
  output logic                  jump_o,
  output logic                  jreg_o,
  output logic                  illegal_o
);

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rd_f, rs1_f, rs2_f;
  logic [31:0]       imm_i, imm_s, imm_br, imm_u, imm_j, imm32;
  alu_op_e           alu;
  logic              writes_rd;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd_f   = REG_AW'(instr_i[11:7]);
  assign rs1_f  = REG_AW'(instr_i[19:15]);
  assign rs2_f  = REG_AW'(instr_i[24:20]);

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_br = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  assign imm_a_o = XLEN'(pc_i);
  assign imm_b_o = XLEN'($signed(imm32));

  always_comb begin
    alu        = ALU_ADD;
    rs1_o      = '0;
    rs2_o      = '0;
    rd_o       = '0;
    sel_a_o    = 1'b0;
    sel_b_o    = 1'b0;
    imm32      = '0;
    writes_rd  = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    mem_size_o = MEM_BYTE;
    mem_uns_o  = 1'b0;
    branch_o   = 1'b0;
    cond_o     = '0;
    jump_o     = 1'b0;
    jreg_o     = 1'b0;
    illegal_o  = 1'b0;

    case (opcode)
      OPCODE_LUI: begin
        rd_o = rd_f; sel_b_o = 1'b1; imm32 = imm_u; writes_rd = 1'b1;
      end
      OPCODE_AUIPC: begin
        rd_o = rd_f; sel_a_o = 1'b1; sel_b_o = 1'b1; imm32 = imm_u; writes_rd = 1'b1;
      end
      // Link address comes from PC on operand A; imm_b carries the jump target offset.
      OPCODE_JAL: begin
        rd_o = rd_f; sel_a_o = 1'b1; sel_b_o = 1'b1; imm32 = imm_j;
        writes_rd = 1'b1; jump_o = 1'b1;
      end
      OPCODE_JALR: begin
        rd_o = rd_f; rs1_o = rs1_f; sel_a_o = 1'b1; sel_b_o = 1'b1; imm32 = imm_i;
        writes_rd = 1'b1; jump_o = 1'b1; jreg_o = 1'b1;
      end
      OPCODE_BRANCH: begin
        rs1_o = rs1_f; rs2_o = rs2_f; imm32 = imm_br; branch_o = 1'b1; cond_o = funct3;
        case (funct3[2:1])
          2'b00:   alu = ALU_SUB;
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        rd_o = rd_f; rs1_o = rs1_f; sel_b_o = 1'b1; imm32 = imm_i; writes_rd = 1'b1;
        mem_rd_o = 1'b1; mem_size_o = funct3[1:0]; mem_uns_o = funct3[2];
        illegal_o = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPCODE_STORE: begin
        rs1_o = rs1_f; rs2_o = rs2_f; sel_b_o = 1'b1; imm32 = imm_s;
        mem_wr_o = 1'b1; mem_size_o = funct3[1:0]; mem_uns_o = funct3[2];
        illegal_o = (funct3 > 3'd2);
      end
      OPCODE_OPIMM: begin
        rd_o = rd_f; rs1_o = rs1_f; sel_b_o = 1'b1; imm32 = imm_i; writes_rd = 1'b1;
        alu = alu_from_funct3(funct3);
        if ((funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SR)) begin
          if ((funct3 == FUNCT3_SR) && (funct7 == FUNCT7_ALT)) alu = ALU_SRA;
          else if ((funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT)) illegal_o = 1'b1;
        end
      end
      OPCODE_OP: begin
        rd_o = rd_f; rs1_o = rs1_f; rs2_o = rs2_f; writes_rd = 1'b1;
        if (funct7 == FUNCT7_BASE) alu = alu_from_funct3(funct3);
        else if ((funct7 == FUNCT7_ALT) && (funct3 == FUNCT3_ADD)) alu = ALU_SUB;
        else if ((funct7 == FUNCT7_ALT) && (funct3 == FUNCT3_SR)) alu = ALU_SRA;
        else illegal_o = 1'b1;
      end
      OPCODE_FENCE, OPCODE_SYSTEM: ;
      default: illegal_o = 1'b1;
    endcase

    if (illegal_o) begin
      alu = ALU_ADD; rs1_o = '0; rs2_o = '0; rd_o = '0; sel_a_o = 1'b0; sel_b_o = 1'b0;
      imm32 = '0; writes_rd = 1'b0; mem_rd_o = 1'b0; mem_wr_o = 1'b0; mem_size_o = MEM_BYTE;
      mem_uns_o = 1'b0; branch_o = 1'b0; cond_o = '0; jump_o = 1'b0; jreg_o = 1'b0;
    end

    alu_op_o = ALU_OP_W'(alu);
    reg_we_o = writes_rd && (rd_o != '0);
  end

endmodule

// File: rtl/core_decode_stage.sv
// Registered RV32I decode stage: valid/ready on both sides, optional 2-entry skid
// buffer, synchronous flush and synchronous active-high reset.
module core_decode_stage
  import core_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int ALU_OP_W   = 4,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ALU_OP_W-1:0]   out_alu_op,
  output logic [REG_AW-1:0]     out_rs1,
  output logic [REG_AW-1:0]     out_rs2,
  output logic [REG_AW-1:0]     out_rd,
  output logic                  out_sel_a,
  output logic                  out_sel_b,
  output logic [XLEN-1:0]       out_imm_a,
  output logic [XLEN-1:0]       out_imm_b,
  output logic                  out_reg_we,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr,
  output logic [1:0]            out_mem_size,
  output logic                  out_mem_uns,
  output logic                  out_branch,
  output logic [2:0]            out_cond,
  output logic                  out_jump,
  output logic                  out_jreg,
  output logic                  out_illegal
);

  localparam int BW = ADDR_WIDTH + ALU_OP_W + 3 * REG_AW + 2 * XLEN + 15;

  logic [ALU_OP_W-1:0] d_alu_op;
  logic [REG_AW-1:0]   d_rs1, d_rs2, d_rd;
  logic                d_sel_a, d_sel_b, d_reg_we, d_mem_rd, d_mem_wr, d_mem_uns;
  logic                d_branch, d_jump, d_jreg, d_illegal;
  logic [XLEN-1:0]     d_imm_a, d_imm_b;
  logic [1:0]          d_mem_size;
  logic [2:0]          d_cond;

  logic [BW-1:0] dec_bundle, out_q, skid_q;
  logic          out_valid_q, skid_valid_q;
  logic          out_space, accept;

  core_decode_comb #(
    .XLEN(XLEN), .ADDR_WIDTH(ADDR_WIDTH), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)
  ) u_decode (
    .instr_i(in_instr), .pc_i(in_pc), .alu_op_o(d_alu_op),
    .rs1_o(d_rs1), .rs2_o(d_rs2), .rd_o(d_rd), .sel_a_o(d_sel_a), .sel_b_o(d_sel_b),
    .imm_a_o(d_imm_a), .imm_b_o(d_imm_b), .reg_we_o(d_reg_we), .mem_rd_o(d_mem_rd),
    .mem_wr_o(d_mem_wr), .mem_size_o(d_mem_size), .mem_uns_o(d_mem_uns),
    .branch_o(d_branch), .cond_o(d_cond), .jump_o(d_jump), .jreg_o(d_jreg),
    .illegal_o(d_illegal)
  );

  assign dec_bundle = {in_pc, d_alu_op, d_rs1, d_rs2, d_rd, d_sel_a, d_sel_b, d_imm_a,
                       d_imm_b, d_reg_we, d_mem_rd, d_mem_wr, d_mem_size, d_mem_uns,
                       d_branch, d_cond, d_jump, d_jreg, d_illegal};

  assign {out_pc, out_alu_op, out_rs1, out_rs2, out_rd, out_sel_a, out_sel_b, out_imm_a,
          out_imm_b, out_reg_we, out_mem_rd, out_mem_wr, out_mem_size, out_mem_uns,
          out_branch, out_cond, out_jump, out_jreg, out_illegal} = out_q;

  // With the skid buffer in_ready depends only on state, breaking the out_ready path.
  assign out_space = !out_valid_q || out_ready;
  assign in_ready  = (SKID != 0) ? !skid_valid_q : out_space;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_q;

  // The skid slot only fills while the output register is held, so it drains first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (out_space) begin
        out_q       <= dec_bundle;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= dec_bundle;
        skid_valid_q <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage (SKID=1): directed RV32I cases plus randomized traffic,
// compared every cycle against a depth-2 queue model of decoded bundles.
module tb_core_decode_stage;

  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4;
  localparam int A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;

  typedef struct {
    logic [31:0] pc;
    int          alu, rs1, rs2, rd;
    bit          selA, selB;
    logic [31:0] immA, immB;
    bit          we, mrd, mwr;
    int          size;
    bit          uns, br;
    int          cond;
    bit          jmp, jreg, ill;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_imm_a, out_imm_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_sel_a, out_sel_b, out_reg_we, out_mem_rd, out_mem_wr, out_mem_uns;
  logic        out_branch, out_jump, out_jreg, out_illegal;
  logic [1:0]  out_mem_size;
  logic [2:0]  out_cond;

  int      compareCount = 0;
  int      failCount = 0;
  bit      checkEn = 1'b0;
  bundle_t expQ[$];

  core_decode_stage #(
    .XLEN(32), .ADDR_WIDTH(32), .REG_AW(5), .ALU_OP_W(4), .SKID(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_op(out_alu_op), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_sel_a(out_sel_a), .out_sel_b(out_sel_b), .out_imm_a(out_imm_a),
    .out_imm_b(out_imm_b), .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_mem_size(out_mem_size), .out_mem_uns(out_mem_uns),
    .out_branch(out_branch), .out_cond(out_cond), .out_jump(out_jump),
    .out_jreg(out_jreg), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic cmpField(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference decoder: immediates built from arithmetic shifts of the signed word.
  function automatic bundle_t refDecode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic signed [31:0] s;
    logic [31:0] immI, immS, immB, immU, immJ;
    int op, f3, f7;
    int aluOf[8];
    aluOf = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    b = '{default: 0};
    b.pc = pc; b.immA = pc;
    s = ins;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    immI = 32'(s >>> 20);
    immS = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
    immB = (32'(s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    immU = ins & 32'hFFFF_F000;
    immJ = (32'(s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    case (op)
      'h37: begin b.rd = ins[11:7]; b.selB = 1; b.immB = immU; b.we = 1; end
      'h17: begin b.rd = ins[11:7]; b.selA = 1; b.selB = 1; b.immB = immU; b.we = 1; end
      'h6F: begin b.rd = ins[11:7]; b.selA = 1; b.selB = 1; b.immB = immJ; b.we = 1; b.jmp = 1; end
      'h67: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.selA = 1; b.selB = 1; b.immB = immI;
        b.we = 1; b.jmp = 1; b.jreg = 1;
      end
      'h63: begin
        if (f3 == 2 || f3 == 3) b.ill = 1;
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.immB = immB; b.br = 1; b.cond = f3;
        b.alu = (f3 < 2) ? A_SUB : (f3 < 6) ? A_SLT : A_SLTU;
      end
      'h03: begin
        if (f3 == 3 || f3 == 6 || f3 == 7) b.ill = 1;
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.selB = 1; b.immB = immI; b.we = 1;
        b.mrd = 1; b.size = f3 % 4; b.uns = (f3 >= 4);
      end
      'h23: begin
        if (f3 > 2) b.ill = 1;
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.selB = 1; b.immB = immS; b.mwr = 1; b.size = f3;
      end
      'h13: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.selB = 1; b.immB = immI; b.we = 1;
        b.alu = aluOf[f3];
        if ((f3 == 1 || f3 == 5) && f7 != 0 && f7 != 'h20) b.ill = 1;
        if (f3 == 5 && f7 == 'h20) b.alu = A_SRA;
      end
      'h33: begin
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.we = 1;
        if (f7 == 0) b.alu = aluOf[f3];
        else if (f7 == 'h20 && f3 == 0) b.alu = A_SUB;
        else if (f7 == 'h20 && f3 == 5) b.alu = A_SRA;
        else b.ill = 1;
      end
      'h0F, 'h73: ;
      default: b.ill = 1;
    endcase
    if (b.ill) begin
      b = '{default: 0};
      b.pc = pc; b.immA = pc; b.ill = 1;
    end
    if (b.rd == 0) b.we = 0;
    return b;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0]  ops[11];
    int k, sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom();
    k = $urandom_range(0, 11);
    if (k == 11) return r;
    r[6:0] = ops[k];
    if (ops[k] == 7'h33 || ops[k] == 7'h13) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) r[31:25] = 7'h00;
      else if (sel == 1) r[31:25] = 7'h20;
    end
    return r;
  endfunction

  // Queue model: up to two decoded bundles held, ready whenever fewer than two.
  always @(posedge clk) begin
    bit doPop, doPush;
    if (rst || flush) begin
      expQ.delete();
    end else begin
      doPop  = (expQ.size() > 0) && out_ready;
      doPush = in_valid && (expQ.size() < 2);
      if (doPop) void'(expQ.pop_front());
      if (doPush) expQ.push_back(refDecode(in_instr, in_pc));
    end
  end

  task automatic checkOutput();
    bundle_t e;
    cmpField("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
    cmpField("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
    if (expQ.size() > 0 && out_valid === 1'b1) begin
      e = expQ[0];
      cmpField("pc", out_pc, e.pc);
      cmpField("alu_op", 32'(out_alu_op), e.alu);
      cmpField("rs1", 32'(out_rs1), e.rs1);
      cmpField("rs2", 32'(out_rs2), e.rs2);
      cmpField("rd", 32'(out_rd), e.rd);
      cmpField("sel_a", 32'(out_sel_a), 32'(e.selA));
      cmpField("sel_b", 32'(out_sel_b), 32'(e.selB));
      cmpField("imm_a", out_imm_a, e.immA);
      cmpField("imm_b", out_imm_b, e.immB);
      cmpField("reg_we", 32'(out_reg_we), 32'(e.we));
      cmpField("mem_rd", 32'(out_mem_rd), 32'(e.mrd));
      cmpField("mem_wr", 32'(out_mem_wr), 32'(e.mwr));
      cmpField("mem_size", 32'(out_mem_size), e.size);
      cmpField("mem_uns", 32'(out_mem_uns), 32'(e.uns));
      cmpField("branch", 32'(out_branch), 32'(e.br));
      cmpField("cond", 32'(out_cond), e.cond);
      cmpField("jump", 32'(out_jump), 32'(e.jmp));
      cmpField("jreg", 32'(out_jreg), 32'(e.jreg));
      cmpField("illegal", 32'(out_illegal), 32'(e.ill));
    end
  endtask

  always @(negedge clk) if (checkEn) checkOutput();

  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                               input bit ordy, input bit fl, input bit rs);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF10093, I_SUB = 32'h405201B3, I_SRA = 32'h4083D333;
  localparam logic [31:0] I_ADDX0 = 32'h00208033, I_LB = 32'h00430283, I_LBU = 32'h00434283;
  localparam logic [31:0] I_SW = 32'h00732423, I_BAD = 32'h0000007F, I_F7 = 32'h022081B3;
  localparam logic [31:0] I_LUI = 32'h123452B7, I_JAL = 32'hFFDFF0EF, I_BEQ = 32'h00000863;

  initial begin
    bundle_t m;
    // Model pins against hand-decoded instructions.
    m = refDecode(I_ADDI, 32'h0);
    cmpField("model addi imm", m.immB, 32'hFFFF_FFFF);
    cmpField("model addi we", 32'(m.we), 32'd1);
    m = refDecode(I_SRA, 32'h0);
    cmpField("model sra alu", m.alu, 7);
    m = refDecode(I_SW, 32'h0);
    cmpField("model sw imm", m.immB, 32'd8);
    cmpField("model sw size", m.size, 2);
    m = refDecode(I_JAL, 32'h0);
    cmpField("model jal imm", m.immB, 32'hFFFF_FFFC);
    m = refDecode(I_BEQ, 32'h0);
    cmpField("model beq imm", m.immB, 32'd16);
    m = refDecode(I_LUI, 32'h0);
    cmpField("model lui imm", m.immB, 32'h1234_5000);

    applyStimulus(0, '0, '0, 0, 0, 1);
    checkEn = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, 1);
    cmpField("rst out_valid", 32'(out_valid), 32'd0);
    cmpField("rst in_ready", 32'(in_ready), 32'd1);
    cmpField("rst out_pc", out_pc, 32'd0);
    cmpField("rst imm_b", out_imm_b, 32'd0);

    applyStimulus(1, I_ADDI, 32'h100, 1, 0, 0);
    cmpField("addi valid", 32'(out_valid), 32'd1);
    cmpField("addi alu", 32'(out_alu_op), A_ADD);
    cmpField("addi imm_b", out_imm_b, 32'hFFFF_FFFF);
    cmpField("addi we", 32'(out_reg_we), 32'd1);
    cmpField("addi rd", 32'(out_rd), 32'd1);
    applyStimulus(0, '0, '0, 1, 0, 0);
    cmpField("drain valid", 32'(out_valid), 32'd0);

    applyStimulus(1, I_SUB, 32'h104, 0, 0, 0);
    cmpField("sub alu", 32'(out_alu_op), A_SUB);
    applyStimulus(1, I_SRA, 32'h108, 0, 0, 0);
    cmpField("skid in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, I_ADDX0, 32'h10C, 0, 0, 0);
      cmpField("stall pc", out_pc, 32'h104);
      cmpField("stall alu", 32'(out_alu_op), A_SUB);
    end
    applyStimulus(0, '0, '0, 1, 0, 0);
    cmpField("sra alu", 32'(out_alu_op), A_SRA);
    cmpField("sra pc", out_pc, 32'h108);
    applyStimulus(0, '0, '0, 1, 0, 0);

    applyStimulus(1, I_ADDX0, 32'h200, 1, 0, 0);
    cmpField("addx0 we", 32'(out_reg_we), 32'd0);
    applyStimulus(1, I_LB, 32'h204, 1, 0, 0);
    cmpField("lb size", 32'(out_mem_size), 32'd0);
    cmpField("lb uns", 32'(out_mem_uns), 32'd0);
    applyStimulus(1, I_LBU, 32'h208, 1, 0, 0);
    cmpField("lbu uns", 32'(out_mem_uns), 32'd1);
    cmpField("lbu mem_wr", 32'(out_mem_wr), 32'd0);
    applyStimulus(1, I_SW, 32'h20C, 1, 0, 0);
    cmpField("sw size", 32'(out_mem_size), 32'd2);
    cmpField("sw mem_wr", 32'(out_mem_wr), 32'd1);
    applyStimulus(1, I_BAD, 32'h210, 1, 0, 0);
    cmpField("op7f illegal", 32'(out_illegal), 32'd1);
    applyStimulus(1, I_F7, 32'h214, 1, 0, 0);
    cmpField("f7 illegal", 32'(out_illegal), 32'd1);
    cmpField("f7 we", 32'(out_reg_we), 32'd0);

    applyStimulus(1, I_LUI, 32'h300, 0, 0, 0);
    cmpField("pre-flush valid", 32'(out_valid), 32'd1);
    applyStimulus(1, I_ADDI, 32'h304, 0, 1, 0);
    cmpField("flush valid", 32'(out_valid), 32'd0);
    applyStimulus(0, '0, '0, 1, 0, 0);
    cmpField("post-flush valid", 32'(out_valid), 32'd0);

    applyStimulus(1, I_SUB, 32'h400, 0, 0, 0);
    applyStimulus(1, I_SRA, 32'h404, 0, 0, 0);
    applyStimulus(1, I_ADDI, 32'h408, 0, 0, 1);
    cmpField("rst-stall valid", 32'(out_valid), 32'd0);
    applyStimulus(0, '0, '0, 0, 0, 0);
    cmpField("rst-stall in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom() & 32'hFFFF_FFFC,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 299) == 0);
    end
    applyStimulus(0, '0, '0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
